// File: rtl/rotozoom_addr_gen.sv
// rotozoom_addr_gen
//   Scans an OUT_W x OUT_H destination window in raster order for one object
//   and emits, per destination pixel, the wrapped 8-bit source texel
//   coordinate after rotation and zoom about (X_center, Y_center).
//
// Ports
//   ACLK, ARESET         clock (rising edge), asynchronous active-high reset
//   START, FINISH_Read   start request / register stage holds a valid record
//   X_center, Y_center   source centre, integer texels
//   Angle                rotation, 256 steps per turn
//   Zoom                 scale, unsigned Q4.4 (16 = 1.0)
//   READY                downstream accepts the current pixel
//   VALID                SRC_X/SRC_Y/PIX_X/PIX_Y valid
//   SRC_X, SRC_Y         source coordinate, integer part mod 256
//   PIX_X, PIX_Y         destination column / row
//   LAST                 current pixel is (OUT_W-1, OUT_H-1)
//   BUSY                 high from START acceptance until DONE exit
//   NEXT                 one-cycle pulse at frame end
module rotozoom_addr_gen #(
  parameter int unsigned OUT_W = 256,
  parameter int unsigned OUT_H = 256
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       START,
  input  logic       FINISH_Read,
  input  logic [7:0] X_center,
  input  logic [7:0] Y_center,
  input  logic [7:0] Angle,
  input  logic [7:0] Zoom,
  input  logic       READY,
  output logic       VALID,
  output logic [7:0] SRC_X,
  output logic [7:0] SRC_Y,
  output logic [7:0] PIX_X,
  output logic [7:0] PIX_Y,
  output logic       LAST,
  output logic       BUSY,
  output logic       NEXT
);

  localparam int unsigned SH_W  = $clog2(OUT_W) - 1;
  localparam int unsigned SH_H  = $clog2(OUT_H) - 1;
  localparam logic [7:0]  X_MAX = 8'(OUT_W - 1);
  localparam logic [7:0]  Y_MAX = 8'(OUT_H - 1);

  typedef enum logic [2:0] {IDLE, SETUP1, SETUP2, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]         xc_q, yc_q, ang_q, zoom_q;
  logic signed [17:0] du_dx, dv_dx, du_dy, dv_dy;
  logic [19:0]        u, v, row_u, row_v;
  logic [7:0]         pix_x, pix_y;
  logic               valid_q, busy_q;

  // Quarter-wave table: round(256*sin(pi*k/128)), k = 0..64
  function automatic logic [8:0] sin_tab(input logic [6:0] k);
    logic [8:0] t;
    case (k)
      7'd0:  t = 9'd0;   7'd1:  t = 9'd6;   7'd2:  t = 9'd13;  7'd3:  t = 9'd19;  7'd4:  t = 9'd25;
      7'd5:  t = 9'd31;  7'd6:  t = 9'd38;  7'd7:  t = 9'd44;  7'd8:  t = 9'd50;  7'd9:  t = 9'd56;
      7'd10: t = 9'd62;  7'd11: t = 9'd68;  7'd12: t = 9'd74;  7'd13: t = 9'd80;  7'd14: t = 9'd86;
      7'd15: t = 9'd92;  7'd16: t = 9'd98;  7'd17: t = 9'd104; 7'd18: t = 9'd109; 7'd19: t = 9'd115;
      7'd20: t = 9'd121; 7'd21: t = 9'd126; 7'd22: t = 9'd132; 7'd23: t = 9'd137; 7'd24: t = 9'd142;
      7'd25: t = 9'd147; 7'd26: t = 9'd152; 7'd27: t = 9'd157; 7'd28: t = 9'd162; 7'd29: t = 9'd167;
      7'd30: t = 9'd172; 7'd31: t = 9'd177; 7'd32: t = 9'd181; 7'd33: t = 9'd185; 7'd34: t = 9'd190;
      7'd35: t = 9'd194; 7'd36: t = 9'd198; 7'd37: t = 9'd202; 7'd38: t = 9'd206; 7'd39: t = 9'd209;
      7'd40: t = 9'd213; 7'd41: t = 9'd216; 7'd42: t = 9'd220; 7'd43: t = 9'd223; 7'd44: t = 9'd226;
      7'd45: t = 9'd229; 7'd46: t = 9'd231; 7'd47: t = 9'd234; 7'd48: t = 9'd237; 7'd49: t = 9'd239;
      7'd50: t = 9'd241; 7'd51: t = 9'd243; 7'd52: t = 9'd245; 7'd53: t = 9'd247; 7'd54: t = 9'd248;
      7'd55: t = 9'd250; 7'd56: t = 9'd251; 7'd57: t = 9'd252; 7'd58: t = 9'd253; 7'd59: t = 9'd254;
      7'd60: t = 9'd255; 7'd61: t = 9'd255; 7'd62: t = 9'd256; 7'd63: t = 9'd256; 7'd64: t = 9'd256;
      default: t = 9'd0;
    endcase
    return t;
  endfunction

  // Full-turn sine from the quarter table: a[6] mirrors the index, a[7] negates.
  function automatic logic signed [9:0] sin_q(input logic [7:0] a);
    logic [6:0] idx;
    logic [9:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = {1'b0, sin_tab(idx)};
    return a[7] ? -$signed(mag) : $signed(mag);
  endfunction

  logic signed [9:0]  sin_v, cos_v;
  logic signed [17:0] zoom_s, s_prod, c_prod;
  logic signed [19:0] dux_e, dvx_e, duy_e, dvy_e;
  logic [19:0]        u0, v0;
  logic               accept, hs, at_last;

  assign sin_v  = sin_q(ang_q);
  assign cos_v  = sin_q(ang_q + 8'd64);
  assign zoom_s = 18'($signed({1'b0, zoom_q}));
  assign c_prod = 18'(cos_v) * zoom_s;
  assign s_prod = 18'(sin_v) * zoom_s;

  assign dux_e = 20'(du_dx);
  assign dvx_e = 20'(dv_dx);
  assign duy_e = 20'(du_dy);
  assign dvy_e = 20'(dv_dy);

  assign u0 = {xc_q, 12'd0} - (dux_e <<< SH_W) - (duy_e <<< SH_H);
  assign v0 = {yc_q, 12'd0} - (dvx_e <<< SH_W) - (dvy_e <<< SH_H);

  assign accept  = (state == IDLE) && START && FINISH_Read;
  assign hs      = valid_q && READY;
  assign at_last = (pix_x == X_MAX) && (pix_y == Y_MAX);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP1;
      SETUP1:  state_nx = SETUP2;
      SETUP2:  state_nx = RUN;
      RUN:     if (hs && at_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      xc_q    <= '0;
      yc_q    <= '0;
      ang_q   <= '0;
      zoom_q  <= '0;
      du_dx   <= '0;
      dv_dx   <= '0;
      du_dy   <= '0;
      dv_dy   <= '0;
      u       <= '0;
      v       <= '0;
      row_u   <= '0;
      row_v   <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xc_q   <= X_center;
            yc_q   <= Y_center;
            ang_q  <= Angle;
            zoom_q <= Zoom;
            busy_q <= 1'b1;
          end
        end
        SETUP1: begin
          du_dx <= c_prod;
          dv_dx <= s_prod;
          du_dy <= -s_prod;
          dv_dy <= c_prod;
        end
        SETUP2: begin
          u       <= u0;
          v       <= v0;
          row_u   <= u0;
          row_v   <= v0;
          pix_x   <= '0;
          pix_y   <= '0;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (hs) begin
            if (at_last) begin
              // Counters return to 0 rather than stepping past the window.
              valid_q <= 1'b0;
              pix_x   <= '0;
              pix_y   <= '0;
            end else if (pix_x != X_MAX) begin
              pix_x <= pix_x + 8'd1;
              u     <= u + dux_e;
              v     <= v + dvx_e;
            end else begin
              pix_x <= '0;
              pix_y <= pix_y + 8'd1;
              row_u <= row_u + duy_e;
              row_v <= row_v + dvy_e;
              u     <= row_u + duy_e;
              v     <= row_v + dvy_e;
            end
          end
        end
        DONE:    busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign VALID = valid_q;
  assign SRC_X = u[19:12];
  assign SRC_Y = v[19:12];
  assign PIX_X = pix_x;
  assign PIX_Y = pix_y;
  assign LAST  = valid_q && at_last;
  assign BUSY  = busy_q;
  assign NEXT  = (state == DONE);

endmodule

// File: tb/tb_rotozoom_addr_gen.sv
// tb_rotozoom_addr_gen
//   Drives rotozoom_addr_gen in two sizes (256x256 and 4x4) from shared
//   inputs and compares every observed pixel with a closed-form reference:
//   u(px,py) = X*4096 - (W/2)*C + (H/2)*S + px*C - py*S (v likewise), wrapped mod 2^20.
module tb_rotozoom_addr_gen;

  localparam real PI = 3.14159265358979323846;

  logic       ACLK = 1'b0;
  logic       ARESET, START, FINISH_Read, READY;
  logic [7:0] X_center, Y_center, Angle, Zoom;

  logic       a_VALID, a_LAST, a_BUSY, a_NEXT;
  logic [7:0] a_SRC_X, a_SRC_Y, a_PIX_X, a_PIX_Y;
  logic       b_VALID, b_LAST, b_BUSY, b_NEXT;
  logic [7:0] b_SRC_X, b_SRC_Y, b_PIX_X, b_PIX_Y;

  int n_tests = 0;
  int n_fail  = 0;
  int p_x, p_y, p_ang, p_zm;

  rotozoom_addr_gen #(.OUT_W(256), .OUT_H(256)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .FINISH_Read(FINISH_Read),
    .X_center(X_center), .Y_center(Y_center), .Angle(Angle), .Zoom(Zoom),
    .READY(READY), .VALID(a_VALID), .SRC_X(a_SRC_X), .SRC_Y(a_SRC_Y),
    .PIX_X(a_PIX_X), .PIX_Y(a_PIX_Y), .LAST(a_LAST), .BUSY(a_BUSY), .NEXT(a_NEXT)
  );

  rotozoom_addr_gen #(.OUT_W(4), .OUT_H(4)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .FINISH_Read(FINISH_Read),
    .X_center(X_center), .Y_center(Y_center), .Angle(Angle), .Zoom(Zoom),
    .READY(READY), .VALID(b_VALID), .SRC_X(b_SRC_X), .SRC_Y(b_SRC_Y),
    .PIX_X(b_PIX_X), .PIX_Y(b_PIX_Y), .LAST(b_LAST), .BUSY(b_BUSY), .NEXT(b_NEXT)
  );

  always #5 ACLK = ~ACLK;

  // round(256*sin(2*pi*a/256))
  function automatic int tsin(input int a);
    real r;
    r = 256.0 * $sin(2.0 * PI * real'(a % 256) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic logic [15:0] model_src(input int w, input int h, input int x, input int y,
                                            input int ang, input int zm, input int px, input int py);
    longint c, s, u, v;
    c = longint'(tsin(ang + 64)) * zm;
    s = longint'(tsin(ang)) * zm;
    u = longint'(x) * 4096 - (w / 2) * c + (h / 2) * s + px * c - py * s;
    v = longint'(y) * 4096 - (w / 2) * s - (h / 2) * c + px * s + py * c;
    u = u & 64'hFFFFF;
    v = v & 64'hFFFFF;
    return {8'(u >> 12), 8'(v >> 12)};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic reset_pulse();
    ARESET = 1'b1; START = 1'b0; FINISH_Read = 1'b0; READY = 1'b0;
    tick(); tick();
    ARESET = 1'b0;
  endtask

  // Accepting edge happens inside; returns one step after it with inputs scrambled.
  task automatic do_start(input int x, input int y, input int ang, input int zm);
    p_x = x; p_y = y; p_ang = ang; p_zm = zm;
    X_center = 8'(x); Y_center = 8'(y); Angle = 8'(ang); Zoom = 8'(zm);
    START = 1'b1; FINISH_Read = 1'b1;
    tick();
    START = 1'b0; FINISH_Read = 1'($urandom);
    X_center = 8'($urandom); Y_center = 8'($urandom); Angle = 8'($urandom); Zoom = 8'($urandom);
  endtask

  task automatic test_reset();
    ARESET = 1'b1; START = 1'b0; FINISH_Read = 1'b0; READY = 1'b0;
    X_center = '0; Y_center = '0; Angle = '0; Zoom = '0;
    #2;
    n_tests++;
    if ({a_VALID, a_SRC_X, a_SRC_Y, a_PIX_X, a_PIX_Y, a_LAST, a_BUSY, a_NEXT} !== 43'd0) begin
      n_fail++; $display("FAIL reset_a got v=%b sx=%0d sy=%0d px=%0d py=%0d l=%b b=%b n=%b exp all 0",
        a_VALID, a_SRC_X, a_SRC_Y, a_PIX_X, a_PIX_Y, a_LAST, a_BUSY, a_NEXT);
    end
    START = 1'b1; FINISH_Read = 1'b1;
    tick(); tick();
    n_tests++;
    if ({b_VALID, b_SRC_X, b_SRC_Y, b_PIX_X, b_PIX_Y, b_LAST, b_BUSY, b_NEXT} !== 43'd0) begin
      n_fail++; $display("FAIL reset_b got v=%b sx=%0d sy=%0d px=%0d py=%0d l=%b b=%b n=%b exp all 0",
        b_VALID, b_SRC_X, b_SRC_Y, b_PIX_X, b_PIX_Y, b_LAST, b_BUSY, b_NEXT);
    end
    START = 1'b0; FINISH_Read = 1'b0;
    ARESET = 1'b0;
    tick();
  endtask

  // Streams nk pixels of the 256x256 unit with READY=1, checking three fixed texels.
  task automatic run_fixed(input string name, input int x, input int y, input int ang, input int zm,
                           input int nk, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t256);
    logic [15:0] e_src;
    int px, py;
    reset_pulse();
    READY = 1'b1;
    do_start(x, y, ang, zm);
    n_tests++;
    if (a_VALID !== 1'b0 || a_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL %s_lat0 got valid=%b busy=%b exp valid=0 busy=1", name, a_VALID, a_BUSY);
    end
    tick();
    n_tests++;
    if (a_VALID !== 1'b0) begin
      n_fail++; $display("FAIL %s_lat1 got valid=%b exp 0", name, a_VALID);
    end
    tick();
    for (int k = 0; k < nk; k++) begin
      px = k % 256; py = k / 256;
      e_src = model_src(256, 256, p_x, p_y, p_ang, p_zm, px, py);
      n_tests++;
      if ({a_VALID, a_LAST, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y} !== {1'b1, 1'b0, 8'(px), 8'(py), e_src}) begin
        n_fail++; $display("FAIL %s_seq k=%0d got v=%b l=%b pix=(%0d,%0d) src=(%0d,%0d) exp pix=(%0d,%0d) src=(%0d,%0d)",
          name, k, a_VALID, a_LAST, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y, px, py, e_src[15:8], e_src[7:0]);
      end
      if (k == 0 || k == 1 || k == 256) begin
        e_src = (k == 0) ? t0 : ((k == 1) ? t1 : t256);
        n_tests++;
        if ({a_SRC_X, a_SRC_Y} !== e_src) begin
          n_fail++; $display("FAIL %s_fixed k=%0d got src=(%0d,%0d) exp src=(%0d,%0d)",
            name, k, a_SRC_X, a_SRC_Y, e_src[15:8], e_src[7:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_identity();
    run_fixed("identity", 128, 128, 0, 16, 258, 16'h0000, 16'h0100, 16'h0001);
  endtask

  task automatic test_rot90();
    run_fixed("rot90", 128, 128, 64, 16, 258, 16'h0000, 16'h0001, 16'hFF00);
  endtask

  task automatic test_zoom2();
    run_fixed("zoom2", 128, 128, 0, 32, 258, 16'h8080, 16'h8280, 16'h8082);
  endtask

  task automatic test_backpressure();
    logic [15:0] e_src;
    int idx;
    reset_pulse();
    READY = 1'b1;
    do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 1));
    tick(); tick();
    idx = 0;
    for (int cyc = 0; cyc < 160; cyc++) begin
      READY = !(cyc >= 100 && cyc < 105);
      e_src = model_src(256, 256, p_x, p_y, p_ang, p_zm, idx % 256, idx / 256);
      n_tests++;
      if ({a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y} !== {1'b1, 8'(idx % 256), 8'(idx / 256), e_src}) begin
        n_fail++; $display("FAIL backpressure cyc=%0d idx=%0d got v=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
          cyc, idx, a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y, e_src[15:8], e_src[7:0]);
      end
      if (READY) idx++;
      tick();
    end
    n_tests++;
    if (idx != 155) begin
      n_fail++; $display("FAIL backpressure_count got %0d exp 155", idx);
    end
  endtask

  task automatic test_frame_end();
    logic [15:0] e_src;
    int hs, next_cnt, last_cyc, next_cyc;
    reset_pulse();
    do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 1));
    hs = 0; next_cnt = 0; last_cyc = -10; next_cyc = -20;
    for (int cyc = 0; cyc < 60; cyc++) begin
      READY = (cyc >= 40) ? 1'b1 : 1'(($urandom % 4) != 0);
      // A START with a valid record while busy must be ignored.
      START = (cyc == 8); FINISH_Read = (cyc == 8);
      if (cyc == 8) begin X_center = X_center + 8'd7; Angle = Angle + 8'd33; end
      if (b_NEXT) begin
        next_cnt++; next_cyc = cyc;
        n_tests++;
        if (b_BUSY !== 1'b1 || b_VALID !== 1'b0) begin
          n_fail++; $display("FAIL frame_done got busy=%b valid=%b exp busy=1 valid=0", b_BUSY, b_VALID);
        end
      end
      if (b_VALID) begin
        e_src = model_src(4, 4, p_x, p_y, p_ang, p_zm, hs % 4, hs / 4);
        n_tests++;
        if ({b_LAST, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y} !== {1'(hs == 15), 8'(hs % 4), 8'(hs / 4), e_src}) begin
          n_fail++; $display("FAIL frame_pix hs=%0d got l=%b pix=(%0d,%0d) src=(%0d,%0d) exp l=%b pix=(%0d,%0d) src=(%0d,%0d)",
            hs, b_LAST, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y, hs == 15, hs % 4, hs / 4, e_src[15:8], e_src[7:0]);
        end
        if (READY) begin
          if (hs == 15) last_cyc = cyc;
          hs++;
        end
      end
      tick();
    end
    START = 1'b0; FINISH_Read = 1'b0;
    n_tests++;
    if (hs != 16) begin n_fail++; $display("FAIL frame_handshakes got %0d exp 16", hs); end
    n_tests++;
    if (next_cnt != 1) begin n_fail++; $display("FAIL frame_next_count got %0d exp 1", next_cnt); end
    n_tests++;
    if (next_cyc != last_cyc + 1) begin
      n_fail++; $display("FAIL frame_next_time got cyc %0d exp %0d", next_cyc, last_cyc + 1);
    end
    n_tests++;
    if (b_BUSY !== 1'b0) begin n_fail++; $display("FAIL frame_busy_drop got %b exp 0", b_BUSY); end
    START = 1'b1; FINISH_Read = 1'b0;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (b_BUSY !== 1'b0 || b_VALID !== 1'b0) begin
      n_fail++; $display("FAIL frame_no_record_start got busy=%b valid=%b exp 0 0", b_BUSY, b_VALID);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e_src;
    int q_x, q_y, q_ang, q_zm;
    reset_pulse();
    READY = 1'b1;
    do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 1));
    q_x = $urandom_range(255, 0); q_y = $urandom_range(255, 0);
    q_ang = $urandom_range(255, 0); q_zm = $urandom_range(255, 1);
    X_center = 8'(q_x); Y_center = 8'(q_y); Angle = 8'(q_ang); Zoom = 8'(q_zm);
    START = 1'b1; FINISH_Read = 1'b1;
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      e_src = model_src(4, 4, p_x, p_y, p_ang, p_zm, k % 4, k / 4);
      n_tests++;
      if ({b_VALID, b_LAST, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y} !== {1'b1, 1'(k == 15), 8'(k % 4), 8'(k / 4), e_src}) begin
        n_fail++; $display("FAIL b2b_frame1 k=%0d got v=%b l=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
          k, b_VALID, b_LAST, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y, e_src[15:8], e_src[7:0]);
      end
      tick();
    end
    n_tests++;
    if ({b_NEXT, b_BUSY, b_VALID} !== 3'b110) begin
      n_fail++; $display("FAIL b2b_done got next=%b busy=%b valid=%b exp 1 1 0", b_NEXT, b_BUSY, b_VALID);
    end
    tick();
    n_tests++;
    if ({b_NEXT, b_BUSY, b_VALID} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_idle got next=%b busy=%b valid=%b exp 0 0 0", b_NEXT, b_BUSY, b_VALID);
    end
    tick();
    n_tests++;
    if ({b_BUSY, b_VALID} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_accept got busy=%b valid=%b exp 1 0", b_BUSY, b_VALID);
    end
    START = 1'b0; FINISH_Read = 1'b0;
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      e_src = model_src(4, 4, q_x, q_y, q_ang, q_zm, k % 4, k / 4);
      n_tests++;
      if ({b_VALID, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y} !== {1'b1, 8'(k % 4), 8'(k / 4), e_src}) begin
        n_fail++; $display("FAIL b2b_frame2 k=%0d got v=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
          k, b_VALID, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y, e_src[15:8], e_src[7:0]);
      end
      tick();
    end
  endtask

  task automatic test_random_params();
    logic [15:0] e_src;
    int ia, ib;
    for (int t = 0; t < 3; t++) begin
      reset_pulse();
      do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0));
      tick(); tick();
      ia = 0; ib = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        READY = 1'(($urandom % 3) != 0);
        e_src = model_src(256, 256, p_x, p_y, p_ang, p_zm, ia % 256, ia / 256);
        n_tests++;
        if ({a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y} !== {1'b1, 8'(ia % 256), 8'(ia / 256), e_src}) begin
          n_fail++; $display("FAIL random_a t=%0d idx=%0d got v=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d) ang=%0d zm=%0d",
            t, ia, a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y, e_src[15:8], e_src[7:0], p_ang, p_zm);
        end
        if (b_VALID) begin
          e_src = model_src(4, 4, p_x, p_y, p_ang, p_zm, ib % 4, ib / 4);
          n_tests++;
          if ({b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y} !== {8'(ib % 4), 8'(ib / 4), e_src}) begin
            n_fail++; $display("FAIL random_b t=%0d idx=%0d got pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
              t, ib, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y, e_src[15:8], e_src[7:0]);
          end
          if (READY) ib++;
        end
        if (READY) ia++;
        tick();
      end
      n_tests++;
      if (ib != 16) begin n_fail++; $display("FAIL random_b_count t=%0d got %0d exp 16", t, ib); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] e_src;
    reset_pulse();
    READY = 1'b1;
    do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 1));
    tick(); tick();
    for (int k = 0; k < 10; k++) tick();
    n_tests++;
    if ({a_PIX_X, b_PIX_X, b_PIX_Y} !== {8'd10, 8'd2, 8'd2}) begin
      n_fail++; $display("FAIL midrun_position got a_px=%0d b=(%0d,%0d) exp 10 (2,2)", a_PIX_X, b_PIX_X, b_PIX_Y);
    end
    ARESET = 1'b1;
    #1;
    n_tests++;
    if ({a_VALID, a_SRC_X, a_SRC_Y, a_PIX_X, a_PIX_Y, a_LAST, a_BUSY, a_NEXT,
         b_VALID, b_SRC_X, b_SRC_Y, b_PIX_X, b_PIX_Y, b_LAST, b_BUSY, b_NEXT} !== 86'd0) begin
      n_fail++; $display("FAIL midrun_async_clear got a v=%b b=%b src=(%0d,%0d) b v=%b b=%b src=(%0d,%0d) exp all 0",
        a_VALID, a_BUSY, a_SRC_X, a_SRC_Y, b_VALID, b_BUSY, b_SRC_X, b_SRC_Y);
    end
    tick(); tick();
    ARESET = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if ({a_NEXT, b_NEXT, a_BUSY, b_BUSY, a_VALID, b_VALID} !== 6'd0) begin
        n_fail++; $display("FAIL midrun_no_next k=%0d got next=%b%b busy=%b%b valid=%b%b exp 0",
          k, a_NEXT, b_NEXT, a_BUSY, b_BUSY, a_VALID, b_VALID);
      end
      tick();
    end
    do_start($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 1));
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      e_src = model_src(256, 256, p_x, p_y, p_ang, p_zm, k, 0);
      n_tests++;
      if ({a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y} !== {1'b1, 8'(k), 8'd0, e_src}) begin
        n_fail++; $display("FAIL midrun_restart_a k=%0d got v=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
          k, a_VALID, a_PIX_X, a_PIX_Y, a_SRC_X, a_SRC_Y, e_src[15:8], e_src[7:0]);
      end
      e_src = model_src(4, 4, p_x, p_y, p_ang, p_zm, k, 0);
      n_tests++;
      if ({b_VALID, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y} !== {1'b1, 8'(k), 8'd0, e_src}) begin
        n_fail++; $display("FAIL midrun_restart_b k=%0d got v=%b pix=(%0d,%0d) src=(%0d,%0d) exp src=(%0d,%0d)",
          k, b_VALID, b_PIX_X, b_PIX_Y, b_SRC_X, b_SRC_Y, e_src[15:8], e_src[7:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rot90();
    test_zoom2();
    test_backpressure();
    test_frame_end();
    test_back_to_back();
    test_random_params();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotozoom_addr_gen.md
Name: rotozoom_addr_gen

Overview:
- Downstream consumer of the global register stage (object count, X_center, Y_center, Angle, Zoom).
- For one object it scans an OUT_W x OUT_H destination window in raster order. For each destination pixel it emits a wrapped 8-bit source texture coordinate (rotation plus zoom about the centre).
- Uses a valid/ready handshake toward the pixel fetch stage.
- At frame end it pulses NEXT back to the register stage to advance the object counter.

Parameters:
- OUT_W, 256, destination window width; power of two, 2..256.
- OUT_H, 256, destination window height; power of two, 2..256.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  asynchronous active-high reset.
- START  in  1  request to process the current object.
- FINISH_Read  in  1  register stage holds a complete, valid object record.
- X_center  in  8  source centre x, integer texels.
- Y_center  in  8  source centre y, integer texels.
- Angle  in  8  rotation, 256 steps per full turn.
- Zoom  in  8  scale, unsigned Q4.4 (16 = 1.0).
- READY  in  1  downstream accepts the current pixel.
- VALID  out  1  SRC_X/SRC_Y/PIX_X/PIX_Y valid.
- SRC_X  out  8  source x, integer part mod 256.
- SRC_Y  out  8  source y, integer part mod 256.
- PIX_X  out  8  destination column.
- PIX_Y  out  8  destination row.
- LAST  out  1  current pixel is (OUT_W-1, OUT_H-1).
- BUSY  out  1  high from START acceptance until DONE.
- NEXT  out  1  one-cycle pulse at frame end.

Behaviour:
- Interface: one clock, ACLK. Reset ARESET is asynchronous, active-high.
- Reset: every output is 0, the FSM is in IDLE, and all accumulators are cleared. Reset asserted mid-frame aborts the frame with no NEXT pulse.
- FSM states: IDLE, SETUP1, SETUP2, RUN, DONE.
- IDLE:
  - START && FINISH_Read latches X_center, Y_center, Angle and Zoom, sets BUSY=1, and moves to SETUP1.
  - START without FINISH_Read is ignored.
  - Later input changes have no effect until the next IDLE.
- Sine table T[0..64] = round(256*sin(pi*k/128)), so T[64]=256; values are 9-bit unsigned.
- sin(a): with q=a[7:6] and i=a[5:0]:
  - q0 gives T[i]; q1 gives T[64-i].
  - q2 gives -T[i]; q3 gives -T[64-i].
  - Result is 10-bit signed.
- cos(a) = sin(a+64 mod 256).
- SETUP1 registers the increments, each a 10b signed x 8b unsigned product, 18-bit signed, 12 fractional bits:
  - C = cos*Zoom, S = sin*Zoom.
  - du_dx = C, dv_dx = S.
  - du_dy = -S, dv_dy = C.
- SETUP2 computes the start point; all coordinate arithmetic is 20-bit two's complement with 12 fractional bits and silent wrap mod 2^20:
  - u0 = X_center<<12 - (OUT_W/2)*du_dx - (OUT_H/2)*du_dy
  - v0 = Y_center<<12 - (OUT_W/2)*dv_dx - (OUT_H/2)*dv_dy
  - Multiplications by powers of two are shifts.
  - u0/v0 are loaded into both the row-start and the current accumulators.
- Latency: VALID rises in the third cycle after the START-accepting edge (RUN entry).
- SRC_X = u[19:12] and SRC_Y = v[19:12]; the texture wraps and is never clamped.
- RUN holds all outputs stable while VALID && !READY. On VALID && READY:
  - If PIX_X != OUT_W-1: PIX_X++, u += du_dx, v += dv_dx.
  - Otherwise: PIX_X=0, PIX_Y++, the row-start accumulators advance by du_dy/dv_dy, and the current accumulators take the new row start.
  - If LAST: VALID=0 next cycle, go to DONE.
- DONE: one cycle. NEXT=1, BUSY falls at exit, return to IDLE. A new START is accepted in IDLE on the following cycle.
- VALID stays high between consecutive accepted pixels; there are no bubbles, so throughput is one pixel per cycle when READY=1.
- START while BUSY is ignored.

Test Plan:
- Identity: Angle=0, Zoom=16, centre (128,128), default params.
  - First pixel is SRC=(0,0) at PIX (0,0).
  - PIX (1,0) gives SRC (1,0); PIX (0,1) gives SRC (0,1).
  - VALID rises exactly 3 cycles after START.
- 90 deg: Angle=64, Zoom=16, centre (128,128).
  - PIX (0,0) gives SRC (0,0).
  - PIX (1,0) gives SRC (0,1).
  - PIX (0,1) gives SRC (255,0), checking wrap.
- Zoom x2: Angle=0, Zoom=32, centre (128,128).
  - PIX (0,0) gives SRC (128,128).
  - PIX (1,0) gives SRC (130,128).
- Backpressure: READY held low 5 cycles mid-row.
  - Outputs are frozen throughout.
  - No pixel is skipped or duplicated, compared against the reference model sequence.
- Frame end: OUT_W=OUT_H=4.
  - Exactly 16 handshakes occur.
  - LAST is high only on PIX (3,3).
  - NEXT pulses once, one cycle after the final handshake.
  - BUSY drops; a START with FINISH_Read=0 is then ignored.
- Reset mid-RUN: assert ARESET at pixel 10.
  - All outputs are 0 asynchronously.
  - No NEXT pulse.
  - A fresh START restarts the frame from PIX (0,0).
